// File: rtl/ym7101_dma_seq.sv
// VDP DMA sequencer: 68k->VDP bus-master transfers into the write FIFO, VRAM fill and VRAM copy.
// Control outputs are decoded from the current state; counters advance only on a completed handshake.
module ym7101_dma_seq #(
  parameter int SRC_W = 22,
  parameter int LEN_W = 16
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic [SRC_W-1:0] cfg_src,
  input  logic [15:0]      cfg_dst,
  input  logic [7:0]       cfg_inc,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             fill_trig,
  input  logic [7:0]       fill_data,
  input  logic             bg_n,
  input  logic             as_n,
  input  logic             bgack_in_n,
  output logic             br_n,
  output logic             bgack_n,
  output logic             mem_req,
  output logic [SRC_W-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [15:0]      mem_rdata,
  output logic             fifo_push,
  input  logic             fifo_full,
  output logic [15:0]      fifo_addr,
  output logic [15:0]      fifo_data,
  output logic             vram_req,
  output logic             vram_we,
  output logic [15:0]      vram_addr,
  output logic [7:0]       vram_wdata,
  input  logic             vram_ack,
  input  logic [7:0]       vram_rdata,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] len_rem,
  output logic [SRC_W-1:0] src_cur
);

  typedef enum logic [3:0] {
    IDLE, BREQ, BGRANT, RD, PUSH, REL, FWAIT, FWR, CRD, CWR
  } state_e;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [15:0]      dst_q, dst_d;
  logic [7:0]       inc_q, inc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      word_q, word_d;
  logic [7:0]       byte_q, byte_d;

  logic             last;
  logic [SRC_W-1:0] src_next;
  logic [15:0]      dst_next;
  logic [LEN_W-1:0] len_next;

  // Source advances inside a 64K-word window: upper bits are never carried into.
  assign src_next = {src_q[SRC_W-1:16], src_q[15:0] + 16'd1};
  assign dst_next = dst_q + {8'h00, inc_q};
  assign len_next = len_q - LEN_W'(1);
  assign last     = (len_q == LEN_W'(1));

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      inc_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      inc_q   <= inc_d;
      len_q   <= len_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    inc_d      = inc_q;
    len_d      = len_q;
    word_d     = word_q;
    byte_d     = byte_q;
    br_n       = 1'b1;
    bgack_n    = 1'b1;
    mem_req    = 1'b0;
    fifo_push  = 1'b0;
    vram_req   = 1'b0;
    vram_we    = 1'b0;
    vram_addr  = dst_q;
    vram_wdata = byte_q;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          src_d = cfg_src;
          dst_d = cfg_dst;
          inc_d = cfg_inc;
          len_d = cfg_len;
          case (cfg_mode)
            2'b10:   state_d = FWAIT;
            2'b11:   state_d = CRD;
            default: state_d = BREQ;
          endcase
        end
      end
      BREQ: begin
        br_n = 1'b0;
        if (!bg_n && as_n && bgack_in_n) state_d = BGRANT;
      end
      BGRANT: begin
        bgack_n = 1'b0;
        state_d = RD;
      end
      RD: begin
        bgack_n = 1'b0;
        mem_req = 1'b1;
        if (mem_ack) begin
          word_d  = mem_rdata;
          state_d = PUSH;
        end
      end
      PUSH: begin
        // The captured word waits here for FIFO space, so a full FIFO never drops data.
        bgack_n = 1'b0;
        if (!fifo_full) begin
          fifo_push = 1'b1;
          src_d     = src_next;
          dst_d     = dst_next;
          len_d     = len_next;
          state_d   = last ? REL : RD;
        end
      end
      REL: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      FWAIT: begin
        if (fill_trig) begin
          byte_d  = fill_data;
          state_d = FWR;
        end
      end
      FWR: begin
        vram_req = 1'b1;
        vram_we  = 1'b1;
        if (vram_ack) begin
          dst_d = dst_next;
          len_d = len_next;
          if (last) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      CRD: begin
        vram_req  = 1'b1;
        vram_addr = src_q[15:0];
        if (vram_ack) begin
          byte_d  = vram_rdata;
          state_d = CWR;
        end
      end
      CWR: begin
        vram_req = 1'b1;
        vram_we  = 1'b1;
        if (vram_ack) begin
          src_d = src_next;
          dst_d = dst_next;
          len_d = len_next;
          if (last) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = CRD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = src_q;
  assign fifo_addr = dst_q;
  assign fifo_data = word_q;
  assign len_rem   = len_q;
  assign src_cur   = src_q;

endmodule

// File: tb/tb_ym7101_dma_seq.sv
// Bench for ym7101_dma_seq: randomized bus/VRAM responders, event monitor, and per-scenario checks
// against transfer sequences computed directly from start address, increment and length.
module tb_ym7101_dma_seq;
  logic        MCLK, RESET, cfg_start, fill_trig, bg_n, as_n, bgack_in_n;
  logic [1:0]  cfg_mode;
  logic [21:0] cfg_src, mem_addr, src_cur;
  logic [15:0] cfg_dst, cfg_len, mem_rdata, fifo_addr, fifo_data, vram_addr, len_rem;
  logic [7:0]  cfg_inc, fill_data, vram_wdata, vram_rdata;
  logic        br_n, bgack_n, mem_req, mem_ack, fifo_push, fifo_full;
  logic        vram_req, vram_we, vram_ack, busy, done;

  int errors = 0;
  int checks = 0;
  logic fast_ack = 1'b1, rand_full = 1'b0, full_force = 1'b0;
  int clr_seq = 0;

  logic [15:0] p_addr[$], p_data[$], w_addr[$], r_addr[$];
  logic [21:0] p_src[$];
  logic [7:0]  w_data[$];
  int done_cnt, br_low_cnt, bgack_bad, memack_cnt;

  ym7101_dma_seq dut (
    .MCLK(MCLK), .RESET(RESET), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_inc(cfg_inc), .cfg_len(cfg_len), .fill_trig(fill_trig),
    .fill_data(fill_data), .bg_n(bg_n), .as_n(as_n), .bgack_in_n(bgack_in_n), .br_n(br_n),
    .bgack_n(bgack_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .fifo_push(fifo_push), .fifo_full(fifo_full), .fifo_addr(fifo_addr),
    .fifo_data(fifo_data), .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata), .busy(busy),
    .done(done), .len_rem(len_rem), .src_cur(src_cur)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  function automatic logic [15:0] mem_model(input logic [21:0] a);
    return a[15:0] ^ 16'hC35A ^ {a[21:16], 10'h000};
  endfunction

  function automatic logic [7:0] vram_model(input logic [15:0] a);
    return (a[7:0] + 8'h11) ^ {a[11:8], a[15:12]};
  endfunction

  // Bus and VRAM responders: update just after each rising edge.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; vram_ack = 1'b0; vram_rdata = '0; fifo_full = 1'b0;
    forever begin
      @(posedge MCLK); #1;
      mem_ack    = mem_req && (fast_ack || $urandom_range(0, 2) == 0);
      mem_rdata  = mem_req ? mem_model(mem_addr) : 16'h0000;
      vram_ack   = vram_req && (fast_ack || $urandom_range(0, 2) == 0);
      vram_rdata = vram_model(vram_addr);
      fifo_full  = full_force || (rand_full && $urandom_range(0, 1) == 0);
    end
  end

  // Monitor: records completed handshakes on the falling edge.
  initial begin
    int seen;
    seen = 0;
    forever begin
      @(negedge MCLK);
      if (clr_seq != seen) begin
        seen = clr_seq;
        p_addr.delete(); p_data.delete(); p_src.delete();
        w_addr.delete(); w_data.delete(); r_addr.delete();
        done_cnt = 0; br_low_cnt = 0; bgack_bad = 0; memack_cnt = 0;
      end
      if (fifo_push) begin
        p_addr.push_back(fifo_addr); p_data.push_back(fifo_data); p_src.push_back(src_cur);
        if (bgack_n) bgack_bad++;
      end
      if (mem_req && bgack_n) bgack_bad++;
      if (mem_req && mem_ack) memack_cnt++;
      if (vram_req && vram_ack && vram_we) begin
        w_addr.push_back(vram_addr); w_data.push_back(vram_wdata);
      end
      if (vram_req && vram_ack && !vram_we) r_addr.push_back(vram_addr);
      if (done) done_cnt++;
      if (!br_n) br_low_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  task automatic clear_log;
    clr_seq++;
    @(negedge MCLK);
    cyc(1);
  endtask

  task automatic start_xfer(input logic [1:0] m, input logic [21:0] s, input logic [15:0] d,
                            input logic [7:0] inc, input logic [15:0] len);
    cfg_mode = m; cfg_src = s; cfg_dst = d; cfg_inc = inc; cfg_len = len;
    cfg_start = 1'b1;
    cyc(1);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin
      cyc(1);
      i++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s timeout: done_cnt=%0d required %0d", name, done_cnt, target);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    cyc(3);
    @(negedge MCLK);
    checks++;
    if ({br_n, bgack_n, busy, done, mem_req, fifo_push, vram_req, vram_we} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=11000000",
               {br_n, bgack_n, busy, done, mem_req, fifo_push, vram_req, vram_we});
    end
    checks++;
    if ({len_rem, src_cur, mem_addr} !== 60'd0) begin
      errors++;
      $display("FAIL reset_counters len_rem=%h src_cur=%h mem_addr=%h required 0", len_rem, src_cur, mem_addr);
    end
    checks++;
    if ({fifo_addr, fifo_data, vram_addr, vram_wdata} !== 56'd0) begin
      errors++;
      $display("FAIL reset_data fifo_addr=%h fifo_data=%h vram_addr=%h vram_wdata=%h required 0",
               fifo_addr, fifo_data, vram_addr, vram_wdata);
    end
    @(posedge MCLK); #1;
    RESET = 1'b1;
    cyc(1);
  endtask

  task automatic test_dma_wrap;
    logic [21:0] es;
    clear_log;
    fast_ack = 1'b1; rand_full = 1'b0; full_force = 1'b0;
    start_xfer(2'b00, 22'h00FFFE, 16'h0000, 8'd2, 16'd3);
    wait_done(1, 100, "wrap_done");
    cyc(3);
    checks++;
    if (p_addr.size() != 3) begin
      errors++; $display("FAIL wrap_count got=%0d required=3", p_addr.size());
    end
    for (int i = 0; i < 3 && i < p_addr.size(); i++) begin
      es = {6'h00, 16'(16'hFFFE + i)};
      checks++;
      if (p_src[i] !== es || p_addr[i] !== 16'(2 * i) || p_data[i] !== mem_model(es)) begin
        errors++;
        $display("FAIL wrap_push%0d src=%h addr=%h data=%h required src=%h addr=%h data=%h",
                 i, p_src[i], p_addr[i], p_data[i], es, 16'(2 * i), mem_model(es));
      end
    end
    checks++;
    if (bgack_bad != 0 || done_cnt != 1) begin
      errors++; $display("FAIL wrap_bus bgack_high=%0d done_cnt=%0d required 0/1", bgack_bad, done_cnt);
    end
    checks++;
    if (len_rem !== 16'h0000 || src_cur !== 22'h000001 || busy !== 1'b0 || br_n !== 1'b1 || bgack_n !== 1'b1) begin
      errors++;
      $display("FAIL wrap_final len_rem=%h src_cur=%h busy=%b br_n=%b bgack_n=%b required 0/000001/0/1/1",
               len_rem, src_cur, busy, br_n, bgack_n);
    end
  endtask

  task automatic test_bus_handshake;
    clear_log;
    fast_ack = 1'b1;
    bg_n = 1'b1; as_n = 1'b0;
    start_xfer(2'b01, 22'h000100, 16'h0000, 8'd1, 16'd1);
    cyc(2);
    @(negedge MCLK);
    checks++;
    if (br_n !== 1'b0 || bgack_n !== 1'b1) begin
      errors++; $display("FAIL hs_request br_n=%b bgack_n=%b required 0/1", br_n, bgack_n);
    end
    @(posedge MCLK); #1;
    bg_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge MCLK);
      checks++;
      if (bgack_n !== 1'b1) begin
        errors++; $display("FAIL hs_as_busy%0d bgack_n=%b required 1", i, bgack_n);
      end
      @(posedge MCLK); #1;
    end
    as_n = 1'b1;
    @(negedge MCLK);
    checks++;
    if (bgack_n !== 1'b1) begin
      errors++; $display("FAIL hs_same_cycle bgack_n=%b required 1", bgack_n);
    end
    @(negedge MCLK);
    checks++;
    if (bgack_n !== 1'b0 || br_n !== 1'b1) begin
      errors++; $display("FAIL hs_grant bgack_n=%b br_n=%b required 0/1", bgack_n, br_n);
    end
    cyc(1);
    wait_done(1, 50, "hs_done");
    checks++;
    if (p_addr.size() != 1) begin
      errors++; $display("FAIL hs_push_count got=%0d required=1", p_addr.size());
    end
  endtask

  task automatic test_fifo_full;
    int i;
    clear_log;
    fast_ack = 1'b1; full_force = 1'b1;
    cyc(1);
    start_xfer(2'b00, 22'h3F0010, 16'h0040, 8'd16, 16'd2);
    i = 0;
    while (memack_cnt < 1 && i < 50) begin cyc(1); i++; end
    checks++;
    if (memack_cnt < 1) begin
      errors++; $display("FAIL ff_read timeout memack=%0d required 1", memack_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge MCLK);
      checks++;
      if (fifo_push !== 1'b0 || mem_req !== 1'b0 || p_addr.size() != 0) begin
        errors++;
        $display("FAIL ff_stall%0d fifo_push=%b mem_req=%b pushes=%0d required 0/0/0",
                 k, fifo_push, mem_req, p_addr.size());
      end
      @(posedge MCLK); #1;
    end
    full_force = 1'b0;
    wait_done(1, 100, "ff_done");
    checks++;
    if (p_addr.size() != 2) begin
      errors++; $display("FAIL ff_count got=%0d required=2", p_addr.size());
    end
    for (int k = 0; k < 2 && k < p_addr.size(); k++) begin
      checks++;
      if (p_src[k] !== 22'(22'h3F0010 + k) || p_data[k] !== mem_model(22'(22'h3F0010 + k))
          || p_addr[k] !== 16'(16'h0040 + 16 * k)) begin
        errors++;
        $display("FAIL ff_push%0d src=%h data=%h addr=%h required src=%h data=%h addr=%h", k,
                 p_src[k], p_data[k], p_addr[k], 22'(22'h3F0010 + k),
                 mem_model(22'(22'h3F0010 + k)), 16'(16'h0040 + 16 * k));
      end
    end
  endtask

  task automatic test_fill;
    clear_log;
    fast_ack = 1'b0;
    start_xfer(2'b10, 22'h000000, 16'h0100, 8'd1, 16'd4);
    cyc(2);
    fill_trig = 1'b1; fill_data = 8'hA5;
    cyc(1);
    fill_trig = 1'b0; fill_data = 8'h00;
    wait_done(1, 200, "fill_done");
    cyc(2);
    checks++;
    if (w_addr.size() != 4 || r_addr.size() != 0) begin
      errors++; $display("FAIL fill_count writes=%0d reads=%0d required 4/0", w_addr.size(), r_addr.size());
    end
    for (int i = 0; i < 4 && i < w_addr.size(); i++) begin
      checks++;
      if (w_addr[i] !== 16'(16'h0100 + i) || w_data[i] !== 8'hA5) begin
        errors++;
        $display("FAIL fill_wr%0d addr=%h data=%h required addr=%h data=a5", i, w_addr[i], w_data[i], 16'(16'h0100 + i));
      end
    end
    checks++;
    if (br_low_cnt != 0 || done_cnt != 1 || len_rem !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_final br_low=%0d done_cnt=%0d len_rem=%h busy=%b required 0/1/0/0",
               br_low_cnt, done_cnt, len_rem, busy);
    end
  endtask

  task automatic test_copy;
    clear_log;
    fast_ack = 1'b0;
    start_xfer(2'b11, 22'h00FFFF, 16'h2000, 8'd1, 16'd2);
    wait_done(1, 200, "copy_done");
    cyc(2);
    checks++;
    if (r_addr.size() != 2 || w_addr.size() != 2) begin
      errors++; $display("FAIL copy_count reads=%0d writes=%0d required 2/2", r_addr.size(), w_addr.size());
    end
    for (int i = 0; i < 2 && i < r_addr.size() && i < w_addr.size(); i++) begin
      checks++;
      if (r_addr[i] !== 16'(16'hFFFF + i) || w_addr[i] !== 16'(16'h2000 + i)
          || w_data[i] !== vram_model(16'(16'hFFFF + i))) begin
        errors++;
        $display("FAIL copy_%0d rd=%h wr=%h data=%h required rd=%h wr=%h data=%h", i, r_addr[i],
                 w_addr[i], w_data[i], 16'(16'hFFFF + i), 16'(16'h2000 + i), vram_model(16'(16'hFFFF + i)));
      end
    end
    checks++;
    if (src_cur !== 22'h000001 || len_rem !== 16'h0000 || br_low_cnt != 0) begin
      errors++;
      $display("FAIL copy_final src_cur=%h len_rem=%h br_low=%0d required 000001/0/0", src_cur, len_rem, br_low_cnt);
    end
  endtask

  task automatic test_random;
    logic [21:0] s, es;
    logic [15:0] d, ea;
    logic [7:0]  inc, fb;
    int len, kind;
    for (int k = 0; k < 9; k++) begin
      kind = k % 3;
      len  = $urandom_range(1, 6);
      s    = 22'($urandom);
      if (k % 2 == 1) s[15:0] = 16'(16'hFFFF - $urandom_range(0, 3));
      d    = 16'($urandom);
      inc  = 8'($urandom);
      fb   = 8'($urandom);
      clear_log;
      fast_ack = 1'b0; rand_full = 1'b1;
      start_xfer(kind == 0 ? 2'(($urandom & 1)) : (kind == 1 ? 2'b10 : 2'b11), s, d, inc, 16'(len));
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_busy busy=%b required 1", k, busy);
      end
      start_xfer(2'b11, ~s, ~d, ~inc, 16'd9);
      if (kind == 1) begin
        cyc(2);
        fill_trig = 1'b1; fill_data = fb;
        cyc(1);
        fill_trig = 1'b0;
      end
      wait_done(1, 500, "rnd_done");
      cyc(2);
      checks++;
      if (done_cnt != 1 || len_rem !== 16'h0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_final done_cnt=%0d len_rem=%h busy=%b required 1/0/0", k, done_cnt, len_rem, busy);
      end
      es = (kind == 1) ? s : {s[21:16], 16'(s[15:0] + len)};
      checks++;
      if (src_cur !== es) begin
        errors++; $display("FAIL rnd%0d_src_cur got=%h required=%h", k, src_cur, es);
      end
      checks++;
      if ((kind == 0 && p_addr.size() != len) || (kind == 1 && w_addr.size() != len)
          || (kind == 2 && (w_addr.size() != len || r_addr.size() != len))) begin
        errors++;
        $display("FAIL rnd%0d_count pushes=%0d writes=%0d reads=%0d required %0d", k,
                 p_addr.size(), w_addr.size(), r_addr.size(), len);
      end
      for (int i = 0; i < len; i++) begin
        es = {s[21:16], 16'(s[15:0] + i)};
        ea = 16'(d + i * inc);
        if (kind == 0 && i < p_addr.size()) begin
          checks++;
          if (p_src[i] !== es || p_addr[i] !== ea || p_data[i] !== mem_model(es)) begin
            errors++;
            $display("FAIL rnd%0d_push%0d src=%h addr=%h data=%h required %h/%h/%h", k, i,
                     p_src[i], p_addr[i], p_data[i], es, ea, mem_model(es));
          end
        end
        if (kind == 1 && i < w_addr.size()) begin
          checks++;
          if (w_addr[i] !== ea || w_data[i] !== fb) begin
            errors++;
            $display("FAIL rnd%0d_fill%0d addr=%h data=%h required %h/%h", k, i, w_addr[i], w_data[i], ea, fb);
          end
        end
        if (kind == 2 && i < w_addr.size() && i < r_addr.size()) begin
          checks++;
          if (r_addr[i] !== es[15:0] || w_addr[i] !== ea || w_data[i] !== vram_model(es[15:0])) begin
            errors++;
            $display("FAIL rnd%0d_copy%0d rd=%h wr=%h data=%h required %h/%h/%h", k, i, r_addr[i],
                     w_addr[i], w_data[i], es[15:0], ea, vram_model(es[15:0]));
          end
        end
      end
      if (kind != 0) begin
        checks++;
        if (br_low_cnt != 0 || p_addr.size() != 0) begin
          errors++; $display("FAIL rnd%0d_nobus br_low=%0d pushes=%0d required 0/0", k, br_low_cnt, p_addr.size());
        end
      end
      rand_full = 1'b0;
    end
  endtask

  task automatic test_len0;
    int i, n;
    clear_log;
    fast_ack = 1'b1; rand_full = 1'b0;
    start_xfer(2'b00, 22'h2A1234, 16'h0000, 8'd1, 16'd0);
    i = 0;
    while (p_addr.size() < 300 && i < 2000) begin cyc(1); i++; end
    n = p_addr.size();
    checks++;
    if (n < 300 || done_cnt != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL len0_run pushes=%0d done_cnt=%0d busy=%b required >=300/0/1", n, done_cnt, busy);
    end
    checks++;
    if (len_rem !== 16'(65536 - n) || src_cur !== {6'h2A, 16'(16'h1234 + n)}) begin
      errors++;
      $display("FAIL len0_counters len_rem=%h src_cur=%h required %h/%h", len_rem, src_cur,
               16'(65536 - n), {6'h2A, 16'(16'h1234 + n)});
    end
    RESET = 1'b0;
    #2;
    checks++;
    if (br_n !== 1'b1 || bgack_n !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || len_rem !== 16'h0000) begin
      errors++;
      $display("FAIL len0_reset br_n=%b bgack_n=%b busy=%b mem_req=%b len_rem=%h required 1/1/0/0/0",
               br_n, bgack_n, busy, mem_req, len_rem);
    end
    cyc(1);
    RESET = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset_mid_copy;
    int i;
    clear_log;
    fast_ack = 1'b0;
    start_xfer(2'b11, 22'h001000, 16'h3000, 8'd1, 16'd20);
    i = 0;
    while (w_addr.size() < 3 && i < 500) begin cyc(1); i++; end
    checks++;
    if (w_addr.size() < 3 || busy !== 1'b1) begin
      errors++; $display("FAIL rcopy_progress writes=%0d busy=%b required >=3/1", w_addr.size(), busy);
    end
    RESET = 1'b0;
    #2;
    checks++;
    if (vram_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || len_rem !== 16'h0000
        || src_cur !== 22'h0 || br_n !== 1'b1 || bgack_n !== 1'b1) begin
      errors++;
      $display("FAIL rcopy_reset vram_req=%b busy=%b done=%b len_rem=%h src_cur=%h br_n=%b bgack_n=%b",
               vram_req, busy, done, len_rem, src_cur, br_n, bgack_n);
    end
    cyc(1);
    RESET = 1'b1;
    cyc(3);
    checks++;
    if (busy !== 1'b0 || vram_req !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL rcopy_idle busy=%b vram_req=%b done_cnt=%0d required 0/0/0", busy, vram_req, done_cnt);
    end
  endtask

  initial begin
    RESET = 1'b0; cfg_start = 1'b0; cfg_mode = 2'b00; cfg_src = '0; cfg_dst = '0; cfg_inc = '0;
    cfg_len = '0; fill_trig = 1'b0; fill_data = '0; bg_n = 1'b0; as_n = 1'b1; bgack_in_n = 1'b1;
    test_reset;
    test_dma_wrap;
    test_bus_handshake;
    test_fifo_full;
    test_fill;
    test_copy;
    test_random;
    test_len0;
    test_reset_mid_copy;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
